// File: rtl/ldpc_pkg.sv
`timescale 1ns / 1ps
// Shared constants, FSM state codes and write-command payload for the LDPC frame-SRAM front end.
package ldpc_pkg;

    localparam int unsigned DEPTH = 800;
    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 20;
    localparam int unsigned BASE  = 0;
    localparam int unsigned CW    = $clog2(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // One registered SRAM write-port beat.
    typedef struct packed {
        logic          wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_cmd_t;

endpackage

// File: rtl/llr_frame_loader_if.sv
`timescale 1ns / 1ps
// Bundle of the loader's upstream stream, decoder handshake and SRAM-side port signals.
interface llr_frame_loader_if;
    import ldpc_pkg::*;

    logic          i_start;
    logic          i_valid;
    logic [DW-1:0] i_data;
    logic          o_ready;
    logic          o_done;
    logic          i_ack;
    logic          i_rreq;
    logic [AW-1:0] i_raddr;
    logic          o_rvalid;
    logic          o_err;
    logic          o_wen;
    logic [AW-1:0] o_waddr;
    logic [DW-1:0] o_wdata;
    logic [AW-1:0] o_raddr;

    modport slave (
        input  i_start, i_valid, i_data, i_ack, i_rreq, i_raddr,
        output o_ready, o_done, o_rvalid, o_err, o_wen, o_waddr, o_wdata, o_raddr
    );

    modport master (
        output i_start, i_valid, i_data, i_ack, i_rreq, i_raddr,
        input  o_ready, o_done, o_rvalid, o_err, o_wen, o_waddr, o_wdata, o_raddr
    );

endinterface

// File: rtl/sram.sv
`timescale 1ns / 1ps
// Frame SRAM: one synchronous write port and one registered-read port; out-of-range accesses are ignored.
module sram
    import ldpc_pkg::*;
(
    input  logic          clk,
    input  logic          i_wen,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wen && (i_waddr < AW'(DEPTH))) begin
            mem[i_waddr[CW-1:0]] <= i_wdata;
        end
        if (i_raddr < AW'(DEPTH)) begin
            o_rdata <= mem[i_raddr[CW-1:0]];
        end
    end

endmodule

// File: rtl/llr_frame_loader.sv
`timescale 1ns / 1ps
// Loads one LLR frame into the frame SRAM, then serves decoder reads until the frame is released.
module llr_frame_loader
    import ldpc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    llr_frame_loader_if.slave  bus
);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ready_q, ready_d;
    logic          done_q, done_d;
    logic          rvalid_q, rvalid_d;
    logic          err_q, err_d;
    wr_cmd_t       wr_q, wr_d;

    logic          beat_c;
    logic          in_done_c;
    logic          rd_ok_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            wr_q     <= '{wen: 1'b0, addr: AW'(BASE), data: DW'(0)};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            wr_q     <= wr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        wr_d.wen  = 1'b0;
        err_d     = err_q;

        in_done_c = (state_q == ST_DONE);
        beat_c    = ready_q && bus.i_valid;
        rd_ok_c   = in_done_c && bus.i_rreq && (bus.i_raddr < AW'(DEPTH));

        case (state_q)
            ST_IDLE: begin
                if (bus.i_start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
            end
            ST_LOAD: begin
                if (beat_c) begin
                    wr_d.wen  = 1'b1;
                    wr_d.addr = AW'(BASE) + AW'(cnt_q);
                    wr_d.data = bus.i_data;
                    // Exit on the last word so cnt never wraps.
                    if (cnt_q == CW'(DEPTH - 1)) begin
                        state_d = ST_DRAIN;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (bus.i_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d  = (state_d == ST_LOAD);
        // o_done trails DONE entry by one cycle so the drained write has landed first.
        done_d   = in_done_c && !bus.i_ack;
        rvalid_d = rd_ok_c;

        if ((bus.i_rreq && !rd_ok_c) ||
            (bus.i_valid && !ready_q) ||
            (bus.i_ack && !in_done_c)) begin
            err_d = 1'b1;
        end
    end

    assign bus.o_ready  = ready_q;
    assign bus.o_done   = done_q;
    assign bus.o_rvalid = rvalid_q;
    assign bus.o_err    = err_q;
    assign bus.o_wen    = wr_q.wen;
    assign bus.o_waddr  = wr_q.addr;
    assign bus.o_wdata  = wr_q.data;
    assign bus.o_raddr  = AW'(BASE) + bus.i_raddr;

endmodule

// File: tb/tb_llr_frame_loader.sv
`timescale 1ns / 1ps
// Bench for llr_frame_loader + sram: control table, full-frame loads and readbacks against a frame model.
module tb_llr_frame_loader;
    import ldpc_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] rdata;

    always #5 clk = ~clk;

    llr_frame_loader_if bus();

    llr_frame_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    sram u_sram (
        .clk     (clk),
        .i_wen   (bus.o_wen),
        .i_waddr (bus.o_waddr),
        .i_wdata (bus.o_wdata),
        .i_raddr (bus.o_raddr),
        .o_rdata (rdata)
    );

    int total = 0;
    int bad   = 0;
    bit exp_err;

    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] frame   [DEPTH];

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;
    wr_t wlog[$];

    typedef struct {
        logic          rst, start, valid, ack, rreq;
        logic [AW-1:0] raddr;
        logic          exp_ready, exp_err, exp_wen, exp_rvalid;
        string         name;
    } ctl_vec_t;
    ctl_vec_t vecs[11];

    // Every write the SRAM sees, captured mid-cycle.
    always @(negedge clk) begin
        if (bus.o_wen === 1'b1) wlog.push_back('{a: bus.o_waddr, d: bus.o_wdata});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_start = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        bus.i_ack   = 1'b0;
        bus.i_rreq  = 1'b0;
        bus.i_raddr = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        rst = 1'b0;
        exp_err = 1'b0;
    endtask

    function automatic ctl_vec_t mk(input logic r, input logic s, input logic v, input logic a,
                                    input logic q, input int ra, input logic er, input logic ee,
                                    input logic ew, input logic ev, input string n);
        ctl_vec_t x;
        x.rst = r; x.start = s; x.valid = v; x.ack = a; x.rreq = q; x.raddr = AW'(ra);
        x.exp_ready = er; x.exp_err = ee; x.exp_wen = ew; x.exp_rvalid = ev; x.name = n;
        return x;
    endfunction

    task automatic fill_frame(input int kind);
        for (int k = 0; k < int'(DEPTH); k++)
            frame[k] = (kind == 0) ? DW'(3 * k) : DW'($urandom);
    endtask

    // gap_mode: 0 continuous, 1 alternate cycles, 2 random idle gaps.
    task automatic load_frame(input string tag, input int gap_mode, input int rreq_at);
        int gaps;
        wlog.delete();
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        check({tag, " ready after start"}, 32'(bus.o_ready), 1);
        for (int k = 0; k < int'(DEPTH); k++) begin
            gaps = (gap_mode == 1) ? ((k > 0) ? 1 : 0) :
                   (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            for (int g = 0; g < gaps; g++) begin
                bus.i_valid = 1'b0;
                step();
            end
            bus.i_valid = 1'b1;
            bus.i_data  = frame[k];
            if (k == rreq_at) begin
                bus.i_rreq  = 1'b1;
                bus.i_raddr = AW'(5);
            end
            step();
            ref_mem[k] = frame[k];
            if (k == rreq_at) begin
                bus.i_rreq = 1'b0;
                exp_err    = 1'b1;
                check({tag, " rreq in LOAD rvalid"}, 32'(bus.o_rvalid), 0);
                check({tag, " rreq in LOAD err"}, 32'(bus.o_err), 1);
            end
        end
        bus.i_valid = 1'b0;
        check({tag, " ready falls on last beat"}, 32'(bus.o_ready), 0);
        check({tag, " done at last beat"}, 32'(bus.o_done), 0);
        step();
        check({tag, " done one after"}, 32'(bus.o_done), 0);
        step();
        check({tag, " done two after"}, 32'(bus.o_done), 1);
        check({tag, " err after load"}, 32'(bus.o_err), 32'(exp_err));
        check_log(tag);
    endtask

    task automatic check_log(input string tag);
        int seq_bad = 0;
        foreach (wlog[i]) begin
            if (wlog[i].a !== AW'(BASE + i) || wlog[i].d !== frame[i]) seq_bad++;
        end
        check({tag, " write count"}, 32'(wlog.size()), DEPTH);
        check({tag, " write order/data errors"}, 32'(seq_bad), 0);
    endtask

    task automatic do_read(input string name, input int addr, input logic exp_v, input int exp_d);
        bus.i_rreq  = 1'b1;
        bus.i_raddr = AW'(addr);
        #1;
        check({name, " o_raddr"}, 32'(bus.o_raddr), 32'(BASE + addr));
        step();
        bus.i_rreq = 1'b0;
        check({name, " rvalid"}, 32'(bus.o_rvalid), 32'(exp_v));
        if (exp_v) check({name, " rdata"}, 32'(rdata), 32'(exp_d));
    endtask

    // Back-to-back reads of every address, one per cycle.
    task automatic readback_all(input string tag);
        int errs = 0;
        for (int a = 0; a < int'(DEPTH); a++) begin
            bus.i_rreq  = 1'b1;
            bus.i_raddr = AW'(a);
            step();
            if (bus.o_rvalid !== 1'b1 || rdata !== ref_mem[a]) errs++;
        end
        bus.i_rreq = 1'b0;
        check({tag, " readback errors"}, 32'(errs), 0);
    endtask

    task automatic random_reads(input string tag, input int n);
        int a;
        for (int i = 0; i < n; i++) begin
            a = int'($urandom_range(0, DEPTH - 1));
            bus.i_rreq  = 1'b1;
            bus.i_raddr = AW'(a);
            step();
            check({tag, " random read"}, {15'd0, bus.o_rvalid, rdata}, {15'd0, 1'b1, ref_mem[a]});
        end
        bus.i_rreq = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        exp_err = 1'b0;
        idle_inputs();
        step();
        check("reset ready", 32'(bus.o_ready), 0);
        check("reset done", 32'(bus.o_done), 0);
        check("reset wen", 32'(bus.o_wen), 0);
        check("reset waddr", 32'(bus.o_waddr), BASE);
        check("reset wdata", 32'(bus.o_wdata), 0);
        check("reset rvalid", 32'(bus.o_rvalid), 0);
        check("reset err", 32'(bus.o_err), 0);

        //            rst  st   vld  ack  rreq raddr rdy  err  wen  rv
        vecs[0]  = mk(1'b1,1'b0,1'b0,1'b0,1'b0, 0,  1'b0,1'b0,1'b0,1'b0, "reset hold");
        vecs[1]  = mk(1'b0,1'b0,1'b1,1'b0,1'b0, 0,  1'b0,1'b1,1'b0,1'b0, "valid in idle");
        vecs[2]  = mk(1'b1,1'b0,1'b0,1'b0,1'b0, 0,  1'b0,1'b0,1'b0,1'b0, "rst clears err");
        vecs[3]  = mk(1'b0,1'b0,1'b0,1'b1,1'b0, 0,  1'b0,1'b1,1'b0,1'b0, "ack in idle");
        vecs[4]  = mk(1'b1,1'b0,1'b0,1'b0,1'b0, 0,  1'b0,1'b0,1'b0,1'b0, "rst again");
        vecs[5]  = mk(1'b0,1'b0,1'b0,1'b0,1'b1, 3,  1'b0,1'b1,1'b0,1'b0, "rreq in idle");
        vecs[6]  = mk(1'b1,1'b0,1'b0,1'b0,1'b0, 0,  1'b0,1'b0,1'b0,1'b0, "rst third");
        vecs[7]  = mk(1'b0,1'b1,1'b0,1'b0,1'b0, 0,  1'b1,1'b0,1'b0,1'b0, "start");
        vecs[8]  = mk(1'b0,1'b1,1'b0,1'b0,1'b0, 0,  1'b1,1'b0,1'b0,1'b0, "start in load");
        vecs[9]  = mk(1'b0,1'b0,1'b1,1'b0,1'b0, 0,  1'b1,1'b0,1'b1,1'b0, "first beat");
        vecs[10] = mk(1'b1,1'b0,1'b0,1'b0,1'b0, 0,  1'b0,1'b0,1'b0,1'b0, "rst mid load");

        for (int i = 0; i < 11; i++) begin
            rst         = vecs[i].rst;
            bus.i_start = vecs[i].start;
            bus.i_valid = vecs[i].valid;
            bus.i_data  = 16'hABCD;
            bus.i_ack   = vecs[i].ack;
            bus.i_rreq  = vecs[i].rreq;
            bus.i_raddr = vecs[i].raddr;
            step();
            check({vecs[i].name, " ready"}, 32'(bus.o_ready), 32'(vecs[i].exp_ready));
            check({vecs[i].name, " err"}, 32'(bus.o_err), 32'(vecs[i].exp_err));
            check({vecs[i].name, " wen"}, 32'(bus.o_wen), 32'(vecs[i].exp_wen));
            check({vecs[i].name, " rvalid"}, 32'(bus.o_rvalid), 32'(vecs[i].exp_rvalid));
        end
        do_reset();

        // Continuous 3k frame and the fixed reads.
        fill_frame(0);
        load_frame("f1", 0, -1);
        do_read("rd0", 0, 1'b1, 0);
        do_read("rd1", 1, 1'b1, 3);
        do_read("rd799", 799, 1'b1, 2397);
        check("err before bad read", 32'(bus.o_err), 0);
        do_read("rd800", 800, 1'b0, 0);
        exp_err = 1'b1;
        check("err after bad read", 32'(bus.o_err), 1);
        readback_all("f1");
        bus.i_ack = 1'b1;
        step();
        bus.i_ack = 1'b0;
        check("ack done", 32'(bus.o_done), 0);
        check("ack ready", 32'(bus.o_ready), 0);
        check("err sticky after ack", 32'(bus.o_err), 1);

        // Alternate-cycle valid, same contents.
        do_reset();
        fill_frame(0);
        load_frame("f2", 1, -1);
        readback_all("f2");
        bus.i_ack = 1'b1;
        step();
        bus.i_ack = 1'b0;

        // Random gaps and data with an illegal read during load.
        fill_frame(1);
        load_frame("f3", 2, 300);
        do_read("f3 rd800", 800, 1'b0, 0);
        check("f3 err sticky", 32'(bus.o_err), 1);
        random_reads("f3", 40);

        // Reset after beat 400 abandons the frame.
        do_reset();
        fill_frame(1);
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        for (int k = 0; k <= 400; k++) begin
            bus.i_valid = 1'b1;
            bus.i_data  = frame[k];
            step();
            ref_mem[k] = frame[k];
        end
        bus.i_valid = 1'b0;
        check("pre-rst wen", 32'(bus.o_wen), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst mid-load wen", 32'(bus.o_wen), 0);
        check("rst mid-load ready", 32'(bus.o_ready), 0);
        check("rst mid-load done", 32'(bus.o_done), 0);
        fill_frame(1);
        load_frame("f4", 0, -1);
        readback_all("f4");

        // Ack and start together in DONE: ack wins, start is dropped.
        bus.i_ack   = 1'b1;
        bus.i_start = 1'b1;
        step();
        bus.i_ack   = 1'b0;
        bus.i_start = 1'b0;
        check("ack+start ready", 32'(bus.o_ready), 0);
        check("ack+start done", 32'(bus.o_done), 0);
        step();
        check("ack+start ready later", 32'(bus.o_ready), 0);
        check("ack+start err", 32'(bus.o_err), 0);

        // Back-to-back frames: ack then start on the next cycle.
        fill_frame(1);
        load_frame("f5a", 0, -1);
        bus.i_ack = 1'b1;
        step();
        bus.i_ack = 1'b0;
        fill_frame(1);
        load_frame("f5b", 2, -1);
        readback_all("f5b");
        check("final err", 32'(bus.o_err), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
